// File: rtl/ro_bank_scheduler.sv
// ro_bank_scheduler: steps through a ring-oscillator bank one RO at a time.
// For each RO it enables the oscillator and waits a settle period. It then
// counts synchronized rising edges over a fixed gate window and offers the
// count on a valid/ready result port.
// Optional feature macro: RO_BANK_BACKGROUND_EN
//   defined   -> every RO is enabled while a sweep is in progress
//   undefined -> only the RO under test is enabled (one-hot)
module ro_bank_scheduler #(
    parameter int NUM_RO        = 150,
    parameter int IDX_W         = $clog2(NUM_RO),
    parameter int CNT_W         = 16,
    parameter int SETTLE_CYCLES = 16,
    parameter int GATE_CYCLES   = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    output logic [NUM_RO-1:0] ro_en,
    input  logic [NUM_RO-1:0] ro_in,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [IDX_W-1:0]  res_idx,
    output logic [CNT_W-1:0]  res_count,
    output logic              res_ovf,
    output logic              busy,
    output logic              done
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_GATE   = 2'd2;
    localparam logic [1:0] ST_REPORT = 2'd3;

    // One shared phase timer covers both SETTLE and GATE.
    localparam int TMR_MAX = (SETTLE_CYCLES > GATE_CYCLES) ? SETTLE_CYCLES : GATE_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX);

    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] GATE_LAST   = TMR_W'(GATE_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_RO - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    logic [1:0]       state_reg, state_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic [TMR_W-1:0] timer_reg, timer_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             ovf_reg, ovf_next;
    logic             done_reg, done_next;

    logic ro_sel;
    logic sync1_reg, sync2_reg, prev_reg;
    logic edge_pulse;

    // Select the RO under test; the result goes straight into the synchronizer.
    always_comb begin
        ro_sel = ro_in[idx_reg];
    end

    // Two-flop synchronizer plus a history flop for rising-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            prev_reg  <= 1'b0;
        end else begin
            sync1_reg <= ro_sel;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
        end
    end

    assign edge_pulse = sync2_reg & ~prev_reg;

    // Sequencer next-state logic; stop overrides every other transition.
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        timer_next = timer_reg;
        count_next = count_reg;
        ovf_next   = ovf_reg;
        done_next  = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_SETTLE;
                    idx_next   = '0;
                    timer_next = '0;
                    count_next = '0;
                    ovf_next   = 1'b0;
                end
            end
            ST_SETTLE: begin
                if (timer_reg == SETTLE_LAST) begin
                    state_next = ST_GATE;
                    timer_next = '0;
                end else begin
                    timer_next = timer_reg + TMR_W'(1);
                end
            end
            ST_GATE: begin
                // Saturate instead of wrapping; flag the lost edge.
                if (edge_pulse) begin
                    if (count_reg == CNT_MAX) begin
                        ovf_next = 1'b1;
                    end else begin
                        count_next = count_reg + CNT_W'(1);
                    end
                end
                if (timer_reg == GATE_LAST) begin
                    state_next = ST_REPORT;
                    timer_next = '0;
                end else begin
                    timer_next = timer_reg + TMR_W'(1);
                end
            end
            default: begin
                if (res_ready) begin
                    if (idx_reg == LAST_IDX) begin
                        state_next = ST_IDLE;
                        done_next  = 1'b1;
                    end else begin
                        state_next = ST_SETTLE;
                        idx_next   = idx_reg + IDX_W'(1);
                        timer_next = '0;
                        count_next = '0;
                        ovf_next   = 1'b0;
                    end
                end
            end
        endcase

        if (stop) begin
            state_next = ST_IDLE;
            timer_next = '0;
            done_next  = 1'b0;
        end
    end

    // Sequencer and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            idx_reg   <= '0;
            timer_reg <= '0;
            count_reg <= '0;
            ovf_reg   <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            timer_reg <= timer_next;
            count_reg <= count_next;
            ovf_reg   <= ovf_next;
            done_reg  <= done_next;
        end
    end

    assign busy      = (state_reg != ST_IDLE);
    assign res_valid = (state_reg == ST_REPORT);
    assign res_idx   = idx_reg;
    assign res_count = count_reg;
    assign res_ovf   = ovf_reg;
    assign done      = done_reg;

    // Per-oscillator enables, all low whenever the sequencer is idle.
    generate
        for (genvar gi = 0; gi < NUM_RO; gi++) begin : g_en
`ifdef RO_BANK_BACKGROUND_EN
            assign ro_en[gi] = busy;
`else
            assign ro_en[gi] = busy && (idx_reg == IDX_W'(gi));
`endif
        end
    endgenerate

endmodule

// File: tb/tb_ro_bank_scheduler.sv
// Directed bench for ro_bank_scheduler with NUM_RO=4, SETTLE=4, GATE=100.
// A second instance with CNT_W=5 shares all inputs to exercise saturation.
module tb_ro_bank_scheduler;

    localparam int N  = 4;
    localparam int S  = 4;
    localparam int G  = 100;
    localparam int LAT = S + G + 1;

    logic         clk;
    logic         rst;
    logic         start;
    logic         stop;
    logic         res_ready;
    logic [N-1:0] ro_in;

    logic [N-1:0] ro_en;
    logic         res_valid;
    logic [1:0]   res_idx;
    logic [7:0]   res_count;
    logic         res_ovf;
    logic         busy;
    logic         done;

    logic [N-1:0] ro_en5;
    logic         res_valid5;
    logic [1:0]   res_idx5;
    logic [4:0]   res_count5;
    logic         res_ovf5;
    logic         busy5;
    logic         done5;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;
    logic fast = 1'b0;

    ro_bank_scheduler #(.NUM_RO(N), .CNT_W(8), .SETTLE_CYCLES(S), .GATE_CYCLES(G)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .ro_en(ro_en), .ro_in(ro_in),
        .res_valid(res_valid), .res_ready(res_ready), .res_idx(res_idx),
        .res_count(res_count), .res_ovf(res_ovf), .busy(busy), .done(done)
    );

    ro_bank_scheduler #(.NUM_RO(N), .CNT_W(5), .SETTLE_CYCLES(S), .GATE_CYCLES(G)) dut5 (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .ro_en(ro_en5), .ro_in(ro_in),
        .res_valid(res_valid5), .res_ready(res_ready), .res_idx(res_idx5),
        .res_count(res_count5), .res_ovf(res_ovf5), .busy(busy5), .done(done5)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Oscillator stand-in: period 4 clocks normally, period 2 clocks when fast.
    initial begin
        logic [1:0] phase;
        logic       ro_bit;
        phase  = '0;
        ro_bit = 1'b0;
        ro_in  = '0;
        forever begin
            @(negedge clk);
            phase = phase + 2'd1;
            if (fast || phase[0]) ro_bit = ~ro_bit;
            ro_in = {N{ro_bit}};
        end
    end

    always @(negedge clk) begin
        if (done) done_cnt++;
    end

    function automatic logic [N-1:0] exp_en(input int k);
`ifdef RO_BANK_BACKGROUND_EN
        return {N{1'b1}};
`else
        return N'(1 << k);
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_rng(input string tag, input logic [31:0] got, input int lo, input int hi);
        n_tests++;
        assert (int'(got) >= lo && int'(got) <= hi) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, got, lo, hi);
        end
    endtask

    // Caller sits at the negedge of cycle 1 of an RO period; returns the
    // cycle number in which res_valid was first seen high (bounded).
    task automatic wait_valid(output int cyc);
        cyc = 1;
        while (!res_valid && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int cyc;
        int d0;
        int bad;
        logic stable;
        logic [N-1:0] s_en;
        logic [1:0]   s_idx;
        logic [7:0]   s_cnt;
        logic         s_ovf;

        rst = 1'b1; start = 1'b0; stop = 1'b0; res_ready = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_ro_en", ro_en, 0);
        check("rst_valid", res_valid, 0);
        check("rst_idx", res_idx, 0);
        check("rst_count", res_count, 0);
        check("rst_ovf", res_ovf, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dut5", {ro_en5, busy5, done5}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Scenario 1: full sweep with ready held high
        d0 = done_cnt;
        pulse_start();
        check("t1_busy_c1", busy, 1);
        check("t1_en_c1", ro_en, exp_en(0));
        for (int k = 0; k < N; k++) begin
            wait_valid(cyc);
            $display("[TB] sweep1 idx=%0d count=%0d ovf=%0d lat=%0d", res_idx, res_count, res_ovf, cyc);
            check("t1_latency", cyc, LAT);
            check("t1_idx", res_idx, k);
            check_rng("t1_count", res_count, 24, 26);
            check("t1_ovf", res_ovf, 0);
            check("t1_en_report", ro_en, exp_en(k));
            if (k == 2) check("t6_en_idx2", ro_en, exp_en(2));
            @(negedge clk);
            check("t1_valid_low", res_valid, 0);
            if (k < N - 1) begin
                check("t1_next_en", ro_en, exp_en(k + 1));
                check("t1_busy", busy, 1);
            end else begin
                check("t1_done", done, 1);
                check("t1_busy_fall", busy, 0);
                check("t1_en_idle", ro_en, 0);
            end
        end
        @(negedge clk);
        check("t1_done_one_cycle", done, 0);
        check("t1_done_count", done_cnt - d0, 1);

        // Scenario 2: backpressure holds the result stable
        res_ready = 1'b0;
        pulse_start();
        wait_valid(cyc);
        check("t2_latency", cyc, LAT);
        s_en = ro_en; s_idx = res_idx; s_cnt = res_count; s_ovf = res_ovf;
        stable = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (!res_valid || ro_en != s_en || res_idx != s_idx ||
                res_count != s_cnt || res_ovf != s_ovf) stable = 1'b0;
        end
        check("t2_stable", stable, 1);
        $display("[TB] stall idx=%0d count=%0d held=%0d", s_idx, s_cnt, stable);
        res_ready = 1'b1;
        @(negedge clk);
        check("t2_valid_low", res_valid, 0);
        check("t2_next_idx", res_idx, 1);
        check("t2_next_en", ro_en, exp_en(1));

        // Scenario 4: stop in the middle of idx 1's gate
        d0 = done_cnt;
        repeat (S + 50) @(negedge clk);
        check("t4_busy_before", busy, 1);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("t4_en", ro_en, 0);
        check("t4_busy", busy, 0);
        check("t4_valid", res_valid, 0);
        bad = 0;
        repeat (150) begin
            @(negedge clk);
            if (res_valid || busy) bad++;
        end
        check("t4_quiet", bad, 0);
        check("t4_no_done", done_cnt - d0, 0);
        $display("[TB] stop idle_violations=%0d", bad);

        // Scenario 3: clk/2 input saturates the 5-bit counter
        fast = 1'b1;
        pulse_start();
        check("t4_restart_en", ro_en, exp_en(0));
        wait_valid(cyc);
        $display("[TB] fast idx=%0d cnt8=%0d cnt5=%0d ovf5=%0d", res_idx, res_count, res_count5, res_ovf5);
        check("t3_latency", cyc, LAT);
        check("t3_idx", res_idx, 0);
        check_rng("t3_count8", res_count, 49, 51);
        check("t3_ovf8", res_ovf, 0);
        check("t3_valid5", res_valid5, 1);
        check("t3_idx5", res_idx5, 0);
        check("t3_count5", res_count5, 31);
        check("t3_ovf5", res_ovf5, 1);
        @(negedge clk);
        res_ready = 1'b0;

        // Scenario 5: reset while reporting, then start+stop together
        wait_valid(cyc);
        check("t5_latency", cyc, LAT);
        check("t5_idx_before", res_idx, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_valid", res_valid, 0);
        check("t5_idx", res_idx, 0);
        check("t5_count", res_count, 0);
        check("t5_ovf", res_ovf, 0);
        check("t5_busy", busy, 0);
        check("t5_en", ro_en, 0);
        check("t5_done", done, 0);
        check("t5_count5", {res_count5, res_ovf5}, 0);
        $display("[TB] reset-in-report valid=%0d busy=%0d", res_valid, busy);
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        check("t5_startstop_busy", busy, 0);
        check("t5_startstop_en", ro_en, 0);
        @(negedge clk);
        check("t5_still_idle", busy, 0);
        fast = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ro_bank_scheduler.md
# ro_bank_scheduler

Sequencer and frequency meter for the mux-based ring-oscillator bank on the test FPGA. It steps through the bank one oscillator at a time:
- enables the oscillator under test;
- lets it settle;
- counts its synchronized rising edges over a fixed gate window;
- hands each count to the readout logic over a valid/ready interface.

It sits between the RO bank (drives enables, samples outputs) and the host-facing readout path.

## Interface
- `NUM_RO`, 150: number of oscillators in the bank.
- `IDX_W`, `$clog2(NUM_RO)`: index width.
- `CNT_W`, 16: edge-counter width.
- `SETTLE_CYCLES`, 16: clocks between enabling an RO and opening the gate (≥ 3).
- `GATE_CYCLES`, 4096: gate window length in clocks (≥ 1).
- `clk`  in  1  single system clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  level-sampled; begins a sweep from index 0 when idle.
- `stop`  in  1  aborts any sweep.
- `ro_en`  out  `NUM_RO`  per-oscillator enable to the bank.
- `ro_in`  in  `NUM_RO`  raw oscillator outputs (asynchronous).
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts result.
- `res_idx`  out  `IDX_W`  index of the measured RO.
- `res_count`  out  `CNT_W`  rising edges counted in the gate.
- `res_ovf`  out  1  count saturated.
- `busy`  out  1  sweep in progress.
- `done`  out  1  one-cycle pulse after the last result is accepted.

## Operation
- States: IDLE, SETTLE, GATE, REPORT.
- IDLE:
  - `ro_en` = 0, `busy` = 0.
  - `start` & !`stop` → SETTLE with idx = 0.
- SETTLE:
  - `ro_en` per Configuration; counter and `res_ovf` cleared on entry.
  - Stays `SETTLE_CYCLES` clocks, then → GATE.
- GATE:
  - Stays exactly `GATE_CYCLES` clocks, then → REPORT.
  - Each rising edge of the selected, synchronized oscillator output increments the counter.
- Edge path:
  - `ro_in[idx]` is selected through a mux, then passed through a 2-flop synchronizer.
  - A registered edge detector produces one count pulse per observed 0→1 transition.
  - Frequencies above clk/2 alias; this is accepted behaviour.
- Counter saturation: the counter saturates at 2^`CNT_W`−1 and `res_ovf` latches to 1; it never wraps.
- REPORT:
  - `res_valid` = 1 with `res_idx`/`res_count`/`res_ovf` held stable; `ro_en` unchanged.
  - On `res_valid` & `res_ready`: if idx = `NUM_RO`−1 → IDLE and pulse `done`; else idx+1 → SETTLE.
- `stop`:
  - Sampled in any state, it forces IDLE on the next edge.
  - Clears `ro_en`, `res_valid` and `busy`.
  - No `done` pulse; any pending result is discarded.
  - `stop` takes priority over `start` and over a simultaneous handshake.
- `start` while busy is ignored.
- Reset values: `ro_en` = 0, `res_valid` = 0, `res_idx` = 0, `res_count` = 0, `res_ovf` = 0, `busy` = 0, `done` = 0, state IDLE. Reset in any state has the same effect as `stop`, and additionally clears the result registers.

## Timing
- `start` sampled at edge 0:
  - SETTLE and `busy` = 1 from cycle 1.
  - `ro_en` asserted from cycle 1.
  - Gate spans cycles `SETTLE_CYCLES`+1 through `SETTLE_CYCLES`+`GATE_CYCLES`.
  - `res_valid` rises at cycle `SETTLE_CYCLES`+`GATE_CYCLES`+1.
- Handshake at edge h:
  - `res_valid` low in cycle h+1.
  - Next RO's `ro_en` is active in cycle h+1.
- Minimum per-RO period: `SETTLE_CYCLES`+`GATE_CYCLES`+1 clocks.
- `done`: high for exactly cycle h+1 after the final handshake; `busy` is low in that same cycle.
- Synchronizer latency (2 clocks) is absorbed by SETTLE. Edges still in the pipeline when the gate closes are not counted.

## Configuration
- `RO_BANK_BACKGROUND_EN`:
  - Defined: while `busy`, all `NUM_RO` enables are high (stress/self-heating mode). Only the measured index feeds the counter.
  - Undefined: `ro_en` is one-hot at idx while busy, which minimises coupling between oscillators.
  - In both cases `ro_en` = 0 when idle.

## Test plan
Test parameters for scenarios 1–5: `NUM_RO`=4, `SETTLE_CYCLES`=4, `GATE_CYCLES`=100, `CNT_W`=8.

1. Drive each `ro_in[k]` as a clock with period 4·clk, `res_ready`=1, pulse `start` → four results in order:
   - idx 0..3, `res_count`=25 (±1), `res_ovf`=0.
   - `done` pulses once; `busy` falls in the same cycle.
2. Hold `res_ready`=0 for 10 cycles after `res_valid` rises → outputs and `ro_en` stable throughout; the sweep resumes on the cycle after ready.
3. Set `CNT_W`=5 and drive `ro_in` at clk/2 (period 2, ~50 edges) → `res_count`=31, `res_ovf`=1.
4. Assert `stop` mid-GATE on idx 1 → next cycle `ro_en`=0, `busy`=0, no `res_valid`, no `done`; a fresh `start` begins again at idx 0.
5. Assert `rst` during REPORT → all outputs at their reset values next cycle. `start` and `stop` asserted together in IDLE → remains IDLE.
6. While measuring idx 2 (`NUM_RO`=4): with `RO_BANK_BACKGROUND_EN` defined, `ro_en`=4'b1111; without it, `ro_en`=4'b0100.
